// File: rtl/tmon_host.sv
// rtl/tmon_host.sv - periodic temperature poller and threshold writer driving tmon_master
// Holds one request at a time, always separated by a NOOP cycle, with a per-request timeout.
package tmon_pkg;
  typedef enum logic [1:0] {
    NOOP      = 2'd0,
    READ_TEMP = 2'd1,
    WRITE_HI  = 2'd2,
    WRITE_LO  = 2'd3
  } TMON_OP;
endpackage

module tmon_host
  import tmon_pkg::*;
#(
  parameter int POLL_PERIOD = 16,
  parameter int TIMEOUT     = 64
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       start,
  input  logic       cfg_wr,
  input  logic [7:0] hi_thresh,
  input  logic [7:0] lo_thresh,
  output TMON_OP     request,
  output logic [7:0] reqData,
  input  logic       Done,
  input  logic [7:0] respData,
  output logic [7:0] temp_out,
  output logic       temp_valid,
  output logic       alarm_hi,
  output logic       alarm_lo,
  output logic       timeout_err,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, WR_HI, WR_LO, READ, WAIT_POLL} state_e;

  localparam int PW = $clog2(POLL_PERIOD + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  state_e        state, nxt;
  logic [7:0]    hi_sh, lo_sh, lo_cur;
  logic          cfg_pending, lo_pending;
  logic [PW-1:0] pcnt;
  logic [TW-1:0] tcnt;
  logic          in_req, done_ok, tmo, entering;

  assign in_req   = (state == WR_HI) || (state == WR_LO) || (state == READ);
  assign done_ok  = in_req && Done;
  assign tmo      = in_req && !Done && (tcnt == TW'(TIMEOUT - 1));
  assign entering = (nxt != state);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= nxt;
  end

  // Every completion returns to a NOOP state, which gives the mandatory gap cycle;
  // lo_pending remembers that the low threshold write is still owed.
  always_comb begin
    nxt = state;
    case (state)
      IDLE, WAIT_POLL: begin
        if (lo_pending)                        nxt = WR_LO;
        else if (cfg_pending)                  nxt = WR_HI;
        else if (state == IDLE || pcnt == '0)  nxt = start ? READ : IDLE;
      end
      WR_HI, WR_LO: if (done_ok || tmo) nxt = IDLE;
      READ: begin
        if (done_ok)  nxt = start ? WAIT_POLL : IDLE;
        else if (tmo) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    request = NOOP;
    busy    = 1'b0;
    case (state)
      WR_HI:   begin request = WRITE_HI;  busy = 1'b1; end
      WR_LO:   begin request = WRITE_LO;  busy = 1'b1; end
      READ:    begin request = READ_TEMP; busy = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      reqData     <= 8'h00;
      temp_out    <= 8'h00;
      temp_valid  <= 1'b0;
      alarm_hi    <= 1'b0;
      alarm_lo    <= 1'b0;
      timeout_err <= 1'b0;
      hi_sh       <= 8'hFF;
      lo_sh       <= 8'h00;
      lo_cur      <= 8'h00;
      cfg_pending <= 1'b0;
      lo_pending  <= 1'b0;
      pcnt        <= '0;
      tcnt        <= '0;
    end else begin
      // Operand is latched on entry so a later cfg_wr cannot disturb a held request.
      if (entering) begin
        case (nxt)
          WR_HI:   reqData <= hi_sh;
          WR_LO:   reqData <= lo_cur;
          default: reqData <= 8'h00;
        endcase
      end

      if (entering)    tcnt <= '0;
      else if (in_req) tcnt <= tcnt + 1'b1;

      if (entering && nxt == WAIT_POLL)       pcnt <= PW'(POLL_PERIOD - 1);
      else if (state == WAIT_POLL && pcnt != '0) pcnt <= pcnt - 1'b1;

      if (cfg_wr) begin
        hi_sh <= hi_thresh;
        lo_sh <= lo_thresh;
      end
      if (cfg_wr)                         cfg_pending <= 1'b1;
      else if (entering && nxt == WR_HI)  cfg_pending <= 1'b0;
      if (entering && nxt == WR_HI)       lo_cur <= lo_sh;

      if (state == WR_HI && done_ok)      lo_pending <= 1'b1;
      else if (entering && nxt == WR_LO)  lo_pending <= 1'b0;

      temp_valid <= (state == READ) && Done;
      if (state == READ && Done) begin
        temp_out <= respData;
        alarm_hi <= respData > hi_sh;
        alarm_lo <= respData < lo_sh;
      end

      if (tmo)         timeout_err <= 1'b1;
      else if (cfg_wr) timeout_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tmon_host.sv
// tb/tb_tmon_host.sv - directed self-checking bench for tmon_host
// A transaction-level model is compared every cycle; run-length literals pin the model.
module tb_tmon_host;
  import tmon_pkg::*;

  localparam int PP = 16;
  localparam int TO = 64;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       start = 1'b0;
  logic       cfg_wr = 1'b0;
  logic       Done = 1'b0;
  logic [7:0] hi_thresh = 8'h00;
  logic [7:0] lo_thresh = 8'h00;
  logic [7:0] respData;
  TMON_OP     request;
  logic [7:0] reqData, temp_out;
  logic       temp_valid, alarm_hi, alarm_lo, timeout_err, busy;

  int checks = 0;
  int errors = 0;

  tmon_host #(.POLL_PERIOD(PP), .TIMEOUT(TO)) dut (
    .Clock(Clock), .Reset(Reset), .start(start), .cfg_wr(cfg_wr),
    .hi_thresh(hi_thresh), .lo_thresh(lo_thresh), .request(request),
    .reqData(reqData), .Done(Done), .respData(respData), .temp_out(temp_out),
    .temp_valid(temp_valid), .alarm_hi(alarm_hi), .alarm_lo(alarm_lo),
    .timeout_err(timeout_err), .busy(busy)
  );

  always #5 Clock = ~Clock;

  // Emulated tmon_master: answers in the resp_lat-th cycle of a held request (0 = never).
  int         resp_lat = 3;
  logic [7:0] resp_val = 8'h19;
  logic       done_force = 1'b0;
  int         held = 0;
  assign respData = resp_val;
  always @(negedge Clock) begin
    if (request == NOOP) held = 0;
    else                 held = held + 1;
    Done = done_force || (resp_lat != 0 && held == resp_lat);
  end

  typedef struct {
    TMON_OP     op;
    int         len;
    logic [7:0] data;
  } run_t;
  run_t runs[$];
  run_t cur = '{NOOP, 0, 8'h00};
  always @(posedge Clock) begin
    #1;
    if (request == cur.op) cur.len++;
    else begin
      runs.push_back(cur);
      cur = '{request, 1, reqData};
    end
  end

  // Model: one outstanding operation, remaining poll wait (-1 = idle), pending config.
  TMON_OP     m_op;
  logic [7:0] m_data, m_temp, m_hi, m_lo, m_locur;
  logic       m_valid, m_ahi, m_alo, m_err, m_pend, m_lopend, m_tmo;
  int         m_age, m_wait;
  always @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      m_op = NOOP; m_data = 8'h00; m_temp = 8'h00; m_valid = 1'b0;
      m_ahi = 1'b0; m_alo = 1'b0; m_err = 1'b0; m_tmo = 1'b0;
      m_hi = 8'hFF; m_lo = 8'h00; m_locur = 8'h00;
      m_pend = 1'b0; m_lopend = 1'b0; m_age = 0; m_wait = -1;
    end else begin
      m_valid = 1'b0;
      m_tmo = 1'b0;
      if (m_op != NOOP) begin
        if (Done) begin
          if (m_op == READ_TEMP) begin
            m_temp = respData; m_valid = 1'b1;
            m_ahi = respData > m_hi; m_alo = respData < m_lo;
            m_wait = start ? PP - 1 : -1;
          end else m_wait = -1;
          if (m_op == WRITE_HI) m_lopend = 1'b1;
          m_op = NOOP; m_data = 8'h00;
        end else if (m_age == TO - 1) begin
          m_err = 1'b1; m_tmo = 1'b1; m_op = NOOP; m_data = 8'h00; m_wait = -1;
        end else m_age++;
      end else if (m_lopend) begin
        m_op = WRITE_LO; m_data = m_locur; m_lopend = 1'b0; m_age = 0; m_wait = -1;
      end else if (m_pend) begin
        m_op = WRITE_HI; m_data = m_hi; m_locur = m_lo; m_pend = 1'b0; m_age = 0; m_wait = -1;
      end else if (m_wait > 0) begin
        m_wait--;
      end else if (start) begin
        m_op = READ_TEMP; m_data = 8'h00; m_age = 0; m_wait = -1;
      end else m_wait = -1;
      if (cfg_wr) begin
        m_hi = hi_thresh; m_lo = lo_thresh; m_pend = 1'b1;
        if (!m_tmo) m_err = 1'b0;
      end
    end
  end

  task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge Clock) begin
    cmp("request", 8'(request), 8'(m_op));
    cmp("reqData", reqData, m_data);
    cmp("busy", 8'(busy), 8'(m_op != NOOP));
    cmp("temp_out", temp_out, m_temp);
    cmp("temp_valid", 8'(temp_valid), 8'(m_valid));
    cmp("alarm_hi", 8'(alarm_hi), 8'(m_ahi));
    cmp("alarm_lo", 8'(alarm_lo), 8'(m_alo));
    cmp("timeout_err", 8'(timeout_err), 8'(m_err));
  end

  task automatic bound_fail(input string name, input int budget);
    checks++;
    errors++;
    $display("FAIL %s: event not seen within %0d cycles", name, budget);
  endtask

  task automatic wait_req(input TMON_OP op, input int budget, input string name);
    int n = 0;
    while (request == op && n < budget) begin @(negedge Clock); n++; end
    while (request != op && n < budget) begin @(negedge Clock); n++; end
    if (request != op) bound_fail(name, budget);
  endtask

  task automatic wait_tv(input int budget, input string name);
    int n = 0;
    while (temp_valid !== 1'b1 && n < budget) begin @(negedge Clock); n++; end
    if (temp_valid !== 1'b1) bound_fail(name, budget);
  endtask

  task automatic wait_runs(input int cnt, input int budget, input string name);
    int n = 0;
    while (runs.size() < cnt && n < budget) begin @(negedge Clock); n++; end
    if (runs.size() < cnt) bound_fail(name, budget);
  endtask

  task automatic expect_run(input int idx, input TMON_OP op, input int len,
                            input logic [7:0] data, input string name);
    checks++;
    if (idx >= runs.size()) begin
      errors++;
      $display("FAIL %s: run %0d missing, only %0d recorded", name, idx, runs.size());
    end else if (runs[idx].op != op || runs[idx].len != len || runs[idx].data !== data) begin
      errors++;
      $display("FAIL %s: got op %0d len %0d data %02h expected op %0d len %0d data %02h",
               name, runs[idx].op, runs[idx].len, runs[idx].data, op, len, data);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    #1 Reset = 1'b0;
    repeat (3) @(negedge Clock);
    cmp("rst_request", 8'(request), 8'(NOOP));
    cmp("rst_reqData", reqData, 8'h00);
    cmp("rst_busy", 8'(busy), 8'h00);
    cmp("rst_temp", temp_out, 8'h00);
    cmp("rst_err", 8'(timeout_err), 8'h00);

    // Basic polling: 3-clock read, 16 NOOP clocks, next read
    base = runs.size();
    Reset = 1'b1; start = 1'b1;
    wait_runs(base + 4, 200, "t1_runs");
    expect_run(base + 1, READ_TEMP, 3, 8'h00, "t1_read");
    expect_run(base + 2, NOOP, PP, 8'h00, "t1_poll_gap");
    expect_run(base + 3, READ_TEMP, 3, 8'h00, "t1_read2");
    cmp("t1_temp", temp_out, 8'h19);
    cmp("t1_alarm_hi", 8'(alarm_hi), 8'h00);
    cmp("t1_alarm_lo", 8'(alarm_lo), 8'h00);

    // Threshold programming then alarms both ways
    start = 1'b0;
    repeat (40) @(negedge Clock);
    base = runs.size();
    hi_thresh = 8'h50; lo_thresh = 8'h10; cfg_wr = 1'b1; resp_val = 8'h60;
    @(negedge Clock);
    cfg_wr = 1'b0; start = 1'b1;
    wait_tv(60, "t2_tv1");
    cmp("t2_temp1", temp_out, 8'h60);
    cmp("t2_ahi1", 8'(alarm_hi), 8'h01);
    cmp("t2_alo1", 8'(alarm_lo), 8'h00);
    resp_val = 8'h05;
    @(negedge Clock);
    wait_tv(60, "t2_tv2");
    cmp("t2_temp2", temp_out, 8'h05);
    cmp("t2_ahi2", 8'(alarm_hi), 8'h00);
    cmp("t2_alo2", 8'(alarm_lo), 8'h01);
    expect_run(base + 1, WRITE_HI, 3, 8'h50, "t2_write_hi");
    expect_run(base + 2, NOOP, 1, 8'h00, "t2_gap1");
    expect_run(base + 3, WRITE_LO, 3, 8'h10, "t2_write_lo");
    expect_run(base + 4, NOOP, 1, 8'h00, "t2_gap2");
    expect_run(base + 5, READ_TEMP, 3, 8'h00, "t2_read");

    // cfg_wr while a read is held
    wait_req(READ_TEMP, 40, "t3_wait");
    base = runs.size();
    hi_thresh = 8'h70; lo_thresh = 8'h08; cfg_wr = 1'b1;
    @(negedge Clock);
    cfg_wr = 1'b0;
    repeat (30) @(negedge Clock);
    expect_run(base, READ_TEMP, 3, 8'h00, "t3_read_untouched");
    expect_run(base + 1, NOOP, 1, 8'h00, "t3_gap");
    expect_run(base + 2, WRITE_HI, 3, 8'h70, "t3_write_hi");
    expect_run(base + 4, WRITE_LO, 3, 8'h08, "t3_write_lo");
    expect_run(base + 6, READ_TEMP, 3, 8'h00, "t3_read");

    // start dropped during a read
    wait_req(READ_TEMP, 40, "t4_wait");
    base = runs.size();
    start = 1'b0; resp_val = 8'h7F;
    repeat (40) @(negedge Clock);
    expect_run(base, READ_TEMP, 3, 8'h00, "t4_read");
    cmp("t4_no_more_requests", 8'(runs.size() - base), 8'h01);
    cmp("t4_temp", temp_out, 8'h7F);
    cmp("t4_alarm_hi", 8'(alarm_hi), 8'h01);
    cmp("t4_idle", 8'(request), 8'(NOOP));

    // Master never answers
    resp_lat = 0; start = 1'b1;
    wait_req(READ_TEMP, 10, "t5_wait");
    base = runs.size();
    start = 1'b0;
    begin
      int n = 0;
      while (timeout_err !== 1'b1 && n < 100) begin @(negedge Clock); n++; end
      if (timeout_err !== 1'b1) bound_fail("t5_err", 100);
    end
    @(negedge Clock);
    expect_run(base, READ_TEMP, TO, 8'h00, "t5_timeout_len");
    cmp("t5_temp_kept", temp_out, 8'h7F);
    repeat (20) @(negedge Clock);
    cmp("t5_err_sticky", 8'(timeout_err), 8'h01);
    cmp("t5_noop", 8'(request), 8'(NOOP));
    resp_lat = 2; hi_thresh = 8'hFF; lo_thresh = 8'h00; cfg_wr = 1'b1;
    @(negedge Clock);
    cfg_wr = 1'b0;
    cmp("t5_err_cleared", 8'(timeout_err), 8'h00);
    repeat (15) @(negedge Clock);

    // Done on the very cycle of the limit
    resp_lat = TO; resp_val = 8'h33; start = 1'b1;
    wait_req(READ_TEMP, 10, "t6_wait");
    base = runs.size();
    start = 1'b0;
    wait_tv(100, "t6_tv");
    @(negedge Clock);
    expect_run(base, READ_TEMP, TO, 8'h00, "t6_done_at_limit");
    cmp("t6_temp", temp_out, 8'h33);
    cmp("t6_no_err", 8'(timeout_err), 8'h00);

    // Reset in the middle of a read, then a stray Done
    resp_lat = 5; start = 1'b1;
    wait_req(READ_TEMP, 10, "t7_wait");
    start = 1'b0;
    @(posedge Clock);
    #2 Reset = 1'b0;
    #1;
    cmp("t7_request", 8'(request), 8'(NOOP));
    cmp("t7_busy", 8'(busy), 8'h00);
    cmp("t7_reqData", reqData, 8'h00);
    cmp("t7_temp", temp_out, 8'h00);
    cmp("t7_valid", 8'(temp_valid), 8'h00);
    @(negedge Clock);
    Reset = 1'b1; done_force = 1'b1;
    repeat (2) @(negedge Clock);
    done_force = 1'b0;
    repeat (5) @(negedge Clock);
    cmp("t7_late_done_req", 8'(request), 8'(NOOP));
    cmp("t7_late_done_temp", temp_out, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
